// File: rtl/mips_exec_pkg.sv
// Shared types and encodings for the MIPS-I execute stage.
// The MIPS_MULTDIV_EN macro (used by the decoder and top) enables MULT/MULTU/DIV/DIVU.
package mips_exec_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_t;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  } alu_ctrl_t;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

endpackage

// File: rtl/mips_exec_alu_decode.sv
// Maps (alu_op, opcode, funct) onto an ALU operation; unknown codes become OP_NOP.
// Mult/div funct codes decode only when MIPS_MULTDIV_EN is defined.
module alu_decode
  import mips_exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    ctrl = OP_NOP;
    case (alu_op_t'(alu_op))
      ALU_ADD: ctrl = OP_ADDU;
      ALU_SUB: ctrl = OP_SUBU;
      ALU_RTYPE: begin
        case (function_code)
          FN_SLL:   ctrl = OP_SLL;
          FN_SRL:   ctrl = OP_SRL;
          FN_SRA:   ctrl = OP_SRA;
          FN_SLLV:  ctrl = OP_SLLV;
          FN_SRLV:  ctrl = OP_SRLV;
          FN_SRAV:  ctrl = OP_SRAV;
`ifdef MIPS_MULTDIV_EN
          FN_MULT:  ctrl = OP_MULT;
          FN_MULTU: ctrl = OP_MULTU;
          FN_DIV:   ctrl = OP_DIV;
          FN_DIVU:  ctrl = OP_DIVU;
`endif
          FN_ADDU:  ctrl = OP_ADDU;
          FN_SUBU:  ctrl = OP_SUBU;
          FN_AND:   ctrl = OP_AND;
          FN_OR:    ctrl = OP_OR;
          FN_XOR:   ctrl = OP_XOR;
          FN_SLT:   ctrl = OP_SLT;
          FN_SLTU:  ctrl = OP_SLTU;
          default:  ctrl = OP_NOP;
        endcase
      end
      ALU_ITYPE: begin
        case (opcode)
          OPC_ADDIU: ctrl = OP_ADDU;
          OPC_SLTI:  ctrl = OP_SLT;
          OPC_SLTIU: ctrl = OP_SLTU;
          OPC_ANDI:  ctrl = OP_AND;
          OPC_ORI:   ctrl = OP_OR;
          OPC_XORI:  ctrl = OP_XOR;
          OPC_LUI:   ctrl = OP_LUI;
          default:   ctrl = OP_NOP;
        endcase
      end
      default: ctrl = OP_NOP;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// MIPS-I execute stage: ALU, hi/lo mult/div results and delayed next-PC selection.
// Define MIPS_MULTDIV_EN to build the multiplier and divider.
module mips_exec_unit
  import mips_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  opcode,
  input  logic [5:0]  function_code,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic [31:0] pc_plus4,
  input  logic        condition_met,
  input  logic        jump1,
  input  logic        jump2,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] tgt_addr_0,
  output logic [31:0] pc_next
);

  alu_ctrl_t   ctrl;
  logic        delay;
  logic [31:0] tgt_hold;

  alu_decode u_decode (
    .alu_op        (alu_op),
    .opcode        (opcode),
    .function_code (function_code),
    .ctrl          (ctrl)
  );

`ifdef MIPS_MULTDIV_EN
  logic [63:0] sprod, uprod;
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'h0, a} * {32'h0, b};
`endif

  always_comb begin
    alu_out = 32'h0;
    hi      = 32'h0;
    lo      = 32'h0;
    case (ctrl)
      OP_ADDU:  alu_out = a + b;
      OP_SUBU:  alu_out = a - b;
      OP_AND:   alu_out = a & b;
      OP_OR:    alu_out = a | b;
      OP_XOR:   alu_out = a ^ b;
      OP_SLT:   alu_out = {31'h0, $signed(a) < $signed(b)};
      OP_SLTU:  alu_out = {31'h0, a < b};
      OP_SLL:   alu_out = b << shamt;
      OP_SRL:   alu_out = b >> shamt;
      OP_SRA:   alu_out = $signed(b) >>> shamt;
      OP_SLLV:  alu_out = b << a[4:0];
      OP_SRLV:  alu_out = b >> a[4:0];
      OP_SRAV:  alu_out = $signed(b) >>> a[4:0];
      OP_LUI:   alu_out = {b[15:0], 16'h0};
`ifdef MIPS_MULTDIV_EN
      OP_MULT:  {hi, lo} = sprod;
      OP_MULTU: {hi, lo} = uprod;
      // Divide by zero leaves hi/lo at 0; the overflow case is pinned explicitly.
      OP_DIV: begin
        if (b == 32'h0) begin
          hi = 32'h0;
          lo = 32'h0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'h0;
          lo = 32'h8000_0000;
        end else begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
        end
      end
      OP_DIVU: begin
        if (b != 32'h0) begin
          lo = a / b;
          hi = a % b;
        end
      end
`endif
      default: alu_out = 32'h0;
    endcase
  end

  assign zero = (alu_out == 32'h0);

  always_comb begin
    if (jump2)              tgt_addr_0 = a;
    else if (jump1)         tgt_addr_0 = jump_addr;
    else if (condition_met) tgt_addr_0 = branch_addr;
    else                    tgt_addr_0 = pc_plus4;
  end

  // Target is held across the delay slot and applied on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay    <= 1'b0;
      tgt_hold <= 32'h0;
    end else if (clk_enable) begin
      if (jump1 || jump2 || condition_met) begin
        delay    <= 1'b1;
        tgt_hold <= tgt_addr_0;
      end else begin
        delay    <= 1'b0;
      end
    end
  end

  assign pc_next = delay ? tgt_hold : pc_plus4;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: vector table, hand sequences, randomized model checks.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        reset, clk_enable;
  logic [1:0]  alu_op;
  logic [5:0]  opcode, function_code;
  logic [4:0]  shamt;
  logic [31:0] a, b, branch_addr, jump_addr, pc_plus4;
  logic        condition_met, jump1, jump2;
  logic [31:0] alu_out, hi, lo, tgt_addr_0, pc_next;
  logic        zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_exec_unit dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .alu_op(alu_op),
    .opcode(opcode), .function_code(function_code), .shamt(shamt),
    .a(a), .b(b), .branch_addr(branch_addr), .jump_addr(jump_addr),
    .pc_plus4(pc_plus4), .condition_met(condition_met), .jump1(jump1),
    .jump2(jump2), .alu_out(alu_out), .zero(zero), .hi(hi), .lo(lo),
    .tgt_addr_0(tgt_addr_0), .pc_next(pc_next)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] va, vb, o, h, l;
    bit          chk_o;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [1:0] op, input logic [5:0] opc,
                         input logic [5:0] fn, input logic [4:0] sh, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] o, input logic [31:0] h,
                         input logic [31:0] l, input bit chk_o);
    vec_t v;
    v.name = name; v.op = op; v.opc = opc; v.fn = fn; v.sh = sh;
    v.va = va; v.vb = vb; v.o = o; v.h = h; v.l = l; v.chk_o = chk_o;
    vecs.push_back(v);
  endtask

  // Reference ALU computed with wide integer arithmetic from the instruction semantics.
  function automatic void ref_alu(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                                  input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb,
                                  output logic [31:0] o, output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, p, q, r, pr;
    logic [63:0] ua, ub, up;
    int          amt;
    string       kind;
    sa = longint'($signed(va)); sb = longint'($signed(vb));
    ua = {32'h0, va}; ub = {32'h0, vb};
    o = 0; h = 0; l = 0; kind = "nop";
    if (op == 2'b00) kind = "add";
    else if (op == 2'b01) kind = "sub";
    else if (op == 2'b10) begin
      case (fn)
        6'h00: kind = "sll";   6'h02: kind = "srl";  6'h03: kind = "sra";
        6'h04: kind = "sllv";  6'h06: kind = "srlv"; 6'h07: kind = "srav";
        6'h18: kind = "mult";  6'h19: kind = "multu";
        6'h1A: kind = "div";   6'h1B: kind = "divu";
        6'h21: kind = "add";   6'h23: kind = "sub";  6'h24: kind = "and";
        6'h25: kind = "or";    6'h26: kind = "xor";  6'h2A: kind = "slt";
        6'h2B: kind = "sltu";  default: kind = "nop";
      endcase
    end else begin
      case (opc)
        6'h09: kind = "add";  6'h0A: kind = "slt";  6'h0B: kind = "sltu";
        6'h0C: kind = "and";  6'h0D: kind = "or";   6'h0E: kind = "xor";
        6'h0F: kind = "lui";  default: kind = "nop";
      endcase
    end
`ifndef MIPS_MULTDIV_EN
    if (kind == "mult" || kind == "multu" || kind == "div" || kind == "divu") kind = "nop";
`endif
    amt = (kind == "sllv" || kind == "srlv" || kind == "srav") ? int'(va % 32) : int'(sh);
    p = longint'(1) << amt;
    case (kind)
      "add":  begin up = ua + ub; o = up[31:0]; end
      "sub":  begin up = ua - ub; o = up[31:0]; end
      "and":  o = va & vb;
      "or":   o = va | vb;
      "xor":  o = va ^ vb;
      "slt":  o = (sa < sb) ? 1 : 0;
      "sltu": o = (ua < ub) ? 1 : 0;
      "sll", "sllv": begin up = ub * 64'(p); o = up[31:0]; end
      "srl", "srlv": begin up = ub / 64'(p); o = up[31:0]; end
      "sra", "srav": begin
        q = sb / p;
        if (sb < 0 && (sb % p) != 0) q = q - 1;
        o = q[31:0];
      end
      "lui":   o = (vb % 65536) * 65536;
      "mult":  begin pr = sa * sb; {h, l} = pr; end
      "multu": begin up = ua * ub; {h, l} = up; end
      "div": if (vb != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      "divu": if (vb != 0) begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      default: o = 0;
    endcase
  endfunction

  task automatic set_ctrl(input logic c, input logic j1, input logic j2);
    condition_met = c; jump1 = j1; jump2 = j2;
  endtask

  initial begin
    logic [31:0] eo, eh, el, exp_tgt, pend;
    logic        pend_v, any;
    logic [5:0]  fns[17];
    logic [5:0]  opcs[7];
    fns  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h19, 6'h1A,
             6'h1B, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
    opcs = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    add_vec("addu_wrap", 2'b00, 6'h0, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1);
    add_vec("subu_zero", 2'b01, 6'h0, 6'h0, 5'd0, 32'd5, 32'd5, 32'h0, 0, 0, 1);
    add_vec("slt",       2'b10, 6'h0, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 1);
    add_vec("sltu",      2'b10, 6'h0, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 1);
    add_vec("sra",       2'b10, 6'h0, 6'h03, 5'd4, 32'h0, 32'h80000000, 32'hF8000000, 0, 0, 1);
    add_vec("sllv",      2'b10, 6'h0, 6'h04, 5'd0, 32'h24, 32'h1, 32'h10, 0, 0, 1);
    add_vec("lui",       2'b11, 6'h0F, 6'h0, 5'd0, 32'h0, 32'h1234ABCD, 32'hABCD0000, 0, 0, 1);
    add_vec("sltiu",     2'b11, 6'h0B, 6'h0, 5'd0, 32'h1, 32'hFFFFFFFF, 32'h1, 0, 0, 1);
    add_vec("nop_funct", 2'b10, 6'h0, 6'h3F, 5'd0, 32'h55, 32'h66, 32'h0, 0, 0, 1);
    add_vec("nop_opc",   2'b11, 6'h3F, 6'h0, 5'd0, 32'h55, 32'h66, 32'h0, 0, 0, 1);
`ifdef MIPS_MULTDIV_EN
    add_vec("mult",   2'b10, 6'h0, 6'h18, 5'd0, 32'hFFFFFFFE, 32'd3, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    add_vec("div",    2'b10, 6'h0, 6'h1A, 5'd0, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    add_vec("div0",   2'b10, 6'h0, 6'h1A, 5'd0, 32'd7, 32'd0, 0, 32'h0, 32'h0, 0);
    add_vec("div_ov", 2'b10, 6'h0, 6'h1A, 5'd0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h80000000, 0);
    add_vec("divu",   2'b10, 6'h0, 6'h1B, 5'd0, 32'hFFFFFFFF, 32'd2, 0, 32'h1, 32'h7FFFFFFF, 0);
`else
    add_vec("mult_off", 2'b10, 6'h0, 6'h18, 5'd0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'h0, 1);
    add_vec("div_off",  2'b10, 6'h0, 6'h1A, 5'd0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'h0, 1);
`endif

    reset = 1'b1; clk_enable = 1'b1; alu_op = 0; opcode = 0; function_code = 0; shamt = 0;
    a = 0; b = 0; branch_addr = 0; jump_addr = 0; pc_plus4 = 32'h4;
    set_ctrl(0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_pc_next", pc_next, 32'h4);

    foreach (vecs[i]) begin
      alu_op = vecs[i].op; opcode = vecs[i].opc; function_code = vecs[i].fn;
      shamt = vecs[i].sh; a = vecs[i].va; b = vecs[i].vb;
      #1;
      if (vecs[i].chk_o) begin
        chk({vecs[i].name, "_out"}, alu_out, vecs[i].o);
        chk({vecs[i].name, "_zero"}, {31'h0, zero}, {31'h0, vecs[i].o == 0});
      end
      chk({vecs[i].name, "_hi"}, hi, vecs[i].h);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].l);
    end

    // JR target, applied after the delay slot, then sequential again.
    a = 32'h10000040; pc_plus4 = 32'h14; set_ctrl(0, 0, 1);
    #1 chk("jr_tgt", tgt_addr_0, 32'h10000040);
    @(posedge clk); #1;
    set_ctrl(0, 0, 0); pc_plus4 = 32'h18;
    #1 chk("jr_slot_pc", pc_next, 32'h10000040);
    @(posedge clk); #1;
    pc_plus4 = 32'h1C;
    #1 chk("jr_after_pc", pc_next, 32'h1C);

    // Priority: jump2 > jump1 > condition_met.
    jump_addr = 32'h3000; branch_addr = 32'h4000; set_ctrl(1, 1, 0);
    #1 chk("prio_j1", tgt_addr_0, 32'h3000);
    set_ctrl(1, 1, 1);
    #1 chk("prio_j2", tgt_addr_0, 32'h10000040);
    set_ctrl(0, 0, 0);
    @(posedge clk); #1;

    // Not-taken branch: decoded as SUBU compare but condition false.
    alu_op = 2'b01;
    for (int i = 0; i < 3; i++) begin
      pc_plus4 = 32'h100 + 4 * i;
      #1 chk("nottaken_pc", pc_next, 32'h100 + 4 * i);
      @(posedge clk); #1;
    end

    // Taken branch, then reset cancels the pending target.
    branch_addr = 32'h200; set_ctrl(1, 0, 0);
    @(posedge clk); #1;
    set_ctrl(0, 0, 0); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; pc_plus4 = 32'h120;
    #1 chk("reset_cancel", pc_next, 32'h120);

    // clk_enable low holds both delay and tgt_hold, and blocks a new load.
    branch_addr = 32'h300; set_ctrl(1, 0, 0);
    @(posedge clk); #1;
    clk_enable = 1'b0; set_ctrl(0, 1, 0); jump_addr = 32'h5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ce_hold", pc_next, 32'h300);
    clk_enable = 1'b1; set_ctrl(0, 0, 0);
    #1 chk("ce_hold2", pc_next, 32'h300);
    @(posedge clk); #1;
    pc_plus4 = 32'h130;
    #1 chk("ce_release", pc_next, 32'h130);

    // Jump in the delay slot: slot target first, new target one cycle later.
    jump_addr = 32'hA00; set_ctrl(0, 1, 0);
    @(posedge clk); #1;
    jump_addr = 32'hB00;
    #1 chk("slot_jump_first", pc_next, 32'hA00);
    @(posedge clk); #1;
    set_ctrl(0, 0, 0);
    #1 chk("slot_jump_second", pc_next, 32'hB00);
    @(posedge clk); #1;
    pc_plus4 = 32'h140;
    #1 chk("slot_jump_done", pc_next, 32'h140);

    // Randomized ALU against the reference model.
    for (int i = 0; i < 400; i++) begin
      alu_op = 2'($urandom_range(3));
      function_code = ($urandom_range(3) != 0) ? fns[$urandom_range(16)] : 6'($urandom);
      opcode = ($urandom_range(3) != 0) ? opcs[$urandom_range(6)] : 6'($urandom);
      shamt = 5'($urandom);
      a = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(15));
        default: b = $urandom;
      endcase
      #1;
      ref_alu(alu_op, opcode, function_code, shamt, a, b, eo, eh, el);
      chk("rand_out", alu_out, eo);
      chk("rand_hi", hi, eh);
      chk("rand_lo", lo, el);
      chk("rand_zero", {31'h0, zero}, {31'h0, eo == 0});
    end

    // Randomized control sequence: a pending target survives exactly one enabled edge.
    pend_v = 1'b0; pend = 32'h0;
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      clk_enable = ($urandom_range(7) != 0);
      reset = ($urandom_range(15) == 0);
      set_ctrl($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
      a = $urandom; jump_addr = $urandom; branch_addr = $urandom; pc_plus4 = $urandom;
      #1;
      exp_tgt = jump2 ? a : jump1 ? jump_addr : condition_met ? branch_addr : pc_plus4;
      chk("rand_tgt", tgt_addr_0, exp_tgt);
      chk("rand_pc_next", pc_next, pend_v ? pend : pc_plus4);
      any = condition_met | jump1 | jump2;
      @(posedge clk);
      if (reset) begin
        pend_v = 1'b0; pend = 32'h0;
      end else if (clk_enable) begin
        pend_v = any;
        if (any) pend = exp_tgt;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
